// File: rtl/fu_issue_if.sv
// fu_issue_if: request/grant bundle between the issue queue and the issue-select scheduler.
interface fu_issue_if #(
  parameter int RS_SIZE   = 16,
  parameter int IDX_W     = 4,
  parameter int FU_SIZE   = 2,
  parameter int FU_ARRAY  = 3,
  parameter int ISSUE_NUM = 3,
  parameter int LAT_W     = 3
);
  logic [RS_SIZE-1:0]           req_valid_in;
  logic [RS_SIZE*FU_SIZE-1:0]   req_fu_in;
  logic [FU_ARRAY*LAT_W-1:0]    fu_latency_in;
  logic                         flush_in;
  logic [RS_SIZE-1:0]           grant_out;
  logic [ISSUE_NUM-1:0]         grant_valid_out;
  logic [ISSUE_NUM*IDX_W-1:0]   grant_idx_out;
  logic [ISSUE_NUM*FU_SIZE-1:0] grant_fu_out;
  logic [FU_ARRAY-1:0]          fu_busy_out;
  logic                         no_issue_out;
  logic [1:0]                   issue_count_out;
  modport master (
    output req_valid_in, req_fu_in, fu_latency_in, flush_in,
    input  grant_out, grant_valid_out, grant_idx_out, grant_fu_out, fu_busy_out, no_issue_out, issue_count_out
  );
  modport slave (
    input  req_valid_in, req_fu_in, fu_latency_in, flush_in,
    output grant_out, grant_valid_out, grant_idx_out, grant_fu_out, fu_busy_out, no_issue_out, issue_count_out
  );
endinterface

// File: rtl/fu_issue_scheduler.sv
// fu_issue_scheduler: round-robin issue select, one grant per FU per cycle, multi-cycle FU occupancy.
module fu_issue_scheduler #(
  parameter int RS_SIZE   = 16,
  parameter int IDX_W     = 4,
  parameter int FU_SIZE   = 2,
  parameter int FU_ARRAY  = 3,
  parameter int ISSUE_NUM = 3,
  parameter int LAT_W     = 3
) (
  input logic       clk,
  input logic       rst,
  fu_issue_if.slave bus
);
  localparam int FU_IDS = 1 << FU_SIZE;
  logic [IDX_W-1:0]           rr_ptr, last_idx;
  logic [LAT_W-1:0]           cnt [FU_ARRAY];
  logic [LAT_W-1:0]           cnt_nxt [FU_ARRAY];
  logic [FU_IDS-1:0]          fu_free, fu_taken;
  logic [RS_SIZE-1:0]         cand, sel_mask;
  logic [ISSUE_NUM-1:0]       sel_valid;
  logic [ISSUE_NUM*IDX_W-1:0] sel_idx;
  logic [ISSUE_NUM*FU_SIZE-1:0] sel_fu;
  logic [1:0]                 sel_cnt;
  assign cand = bus.req_valid_in & ~bus.grant_out;
  // ids at or above FU_ARRAY stay permanently non-free, so they are never granted
  always_comb begin
    fu_free = '0;
    for (int f = 0; f < FU_ARRAY; f++) fu_free[f] = cnt[f] == '0;
  end
  always_comb begin
    logic [IDX_W-1:0]   idx;
    logic [FU_SIZE-1:0] fu;
    sel_mask  = '0;
    sel_valid = '0;
    sel_idx   = '0;
    sel_fu    = '0;
    fu_taken  = '0;
    sel_cnt   = '0;
    last_idx  = rr_ptr;
    idx       = '0;
    fu        = '0;
    for (int k = 0; k < RS_SIZE; k++) begin
      idx = rr_ptr + IDX_W'(k);
      fu  = bus.req_fu_in[idx*FU_SIZE +: FU_SIZE];
      if (cand[idx] && fu_free[fu] && !fu_taken[fu] && sel_cnt < 2'(ISSUE_NUM)) begin
        sel_mask[idx]                       = 1'b1;
        sel_valid[sel_cnt]                  = 1'b1;
        sel_idx[sel_cnt*IDX_W +: IDX_W]     = idx;
        sel_fu[sel_cnt*FU_SIZE +: FU_SIZE]  = fu;
        fu_taken[fu]                        = 1'b1;
        last_idx                            = idx;
        sel_cnt                             = sel_cnt + 2'd1;
      end
    end
  end
  always_comb begin
    logic [LAT_W-1:0] lat;
    lat = '0;
    for (int f = 0; f < FU_ARRAY; f++) begin
      lat        = bus.fu_latency_in[f*LAT_W +: LAT_W];
      cnt_nxt[f] = bus.flush_in ? '0
                 : fu_taken[f] ? (lat > LAT_W'(1) ? lat - LAT_W'(1) : '0)
                 : (cnt[f] != '0 ? cnt[f] - LAT_W'(1) : '0);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr              <= '0;
      bus.grant_out       <= '0;
      bus.grant_valid_out <= '0;
      bus.grant_idx_out   <= '0;
      bus.grant_fu_out    <= '0;
      bus.fu_busy_out     <= '0;
      bus.no_issue_out    <= 1'b0;
      bus.issue_count_out <= '0;
      for (int f = 0; f < FU_ARRAY; f++) cnt[f] <= '0;
    end else begin
      bus.grant_out       <= bus.flush_in ? '0 : sel_mask;
      bus.grant_valid_out <= bus.flush_in ? '0 : sel_valid;
      bus.grant_idx_out   <= bus.flush_in ? '0 : sel_idx;
      bus.grant_fu_out    <= bus.flush_in ? '0 : sel_fu;
      bus.issue_count_out <= bus.flush_in ? '0 : sel_cnt;
      bus.no_issue_out    <= !bus.flush_in && |cand && sel_cnt == '0;
      if (!bus.flush_in && sel_cnt != '0) rr_ptr <= last_idx + IDX_W'(1);
      for (int f = 0; f < FU_ARRAY; f++) begin
        cnt[f]             <= cnt_nxt[f];
        bus.fu_busy_out[f] <= cnt_nxt[f] != '0;
      end
    end
  end
endmodule

// File: tb/tb_fu_issue_scheduler.sv
// tb_fu_issue_scheduler: random and directed stimulus against a timestamp-based reference model.
module tb_fu_issue_scheduler;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   m_rr = 0;
  int   m_free [3];
  logic [15:0] m_prev = '0;
  fu_issue_if bus();
  fu_issue_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  // m_free[f] is the first cycle at which FU f may be granted again
  task automatic tick();
    logic [15:0] eg = '0;
    logic [2:0]  ev = '0;
    logic [11:0] ei = '0;
    logic [5:0]  ef = '0;
    logic [2:0]  eb = '0;
    logic        en = 1'b0;
    int n = 0, last = 0, f = 0, i = 0, lat = 0;
    bit any = 0;
    bit used [3] = '{0, 0, 0};
    if (rst || bus.flush_in) begin
      if (rst) m_rr = 0;
      for (int j = 0; j < 3; j++) m_free[j] = 0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        i = (m_rr + k) % 16;
        f = int'(bus.req_fu_in[i*2 +: 2]);
        if (bus.req_valid_in[i] && !m_prev[i]) begin
          any = 1;
          if (f < 3 && cyc >= m_free[f] && !used[f] && n < 3) begin
            used[f] = 1;
            eg[i] = 1'b1;
            ev[n] = 1'b1;
            ei[n*4 +: 4] = 4'(i);
            ef[n*2 +: 2] = 2'(f);
            last = i;
            n++;
          end
        end
      end
      for (int j = 0; j < 3; j++) begin
        lat = int'(bus.fu_latency_in[j*3 +: 3]);
        if (used[j] && lat > 1) m_free[j] = cyc + lat;
        eb[j] = m_free[j] > cyc + 1;
      end
      if (n > 0) m_rr = (last + 1) % 16;
      en = any && n == 0;
    end
    m_prev = eg;
    @(posedge clk);
    #1;
    check("grant", 32'(bus.grant_out), 32'(eg));
    check("gvalid", 32'(bus.grant_valid_out), 32'(ev));
    check("gidx", 32'(bus.grant_idx_out), 32'(ei));
    check("gfu", 32'(bus.grant_fu_out), 32'(ef));
    check("busy", 32'(bus.fu_busy_out), 32'(eb));
    check("noissue", 32'(bus.no_issue_out), 32'(en));
    check("count", 32'(bus.issue_count_out), 32'(n));
    cyc++;
  endtask
  initial begin
    for (int j = 0; j < 3; j++) m_free[j] = 0;
    rst = 1'b1;
    bus.req_valid_in  = 16'hffff;
    bus.req_fu_in     = '0;
    bus.fu_latency_in = {3'd1, 3'd1, 3'd1};
    bus.flush_in      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    bus.req_valid_in = 16'h0007;
    bus.req_fu_in    = 32'h0000_0024;
    tick();
    check("par_grant", 32'(bus.grant_out), 32'h0007);
    check("par_idx", 32'(bus.grant_idx_out), 32'h210);
    bus.req_valid_in = 16'h2000;
    bus.req_fu_in    = '0;
    tick();
    bus.req_valid_in = 16'h8002;
    bus.req_fu_in    = 32'h4000_0000;
    tick();
    check("wrap_idx", 32'(bus.grant_idx_out), 32'h01f);
    check("wrap_valid", 32'(bus.grant_valid_out), 32'h3);
    bus.req_valid_in = 16'h00f0;
    bus.req_fu_in    = '0;
    repeat (6) tick();
    bus.fu_latency_in = {3'd3, 3'd1, 3'd1};
    bus.req_valid_in  = 16'h0600;
    bus.req_fu_in     = 32'h0028_0000;
    repeat (6) tick();
    bus.req_valid_in = 16'h0200;
    tick();
    bus.flush_in = 1'b1;
    tick();
    check("flush_busy", 32'(bus.fu_busy_out), 32'h0);
    bus.flush_in = 1'b0;
    tick();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(1, 0) == 0) bus.req_valid_in = 16'($urandom);
      if ($urandom_range(3, 0) == 0) bus.req_fu_in = $urandom;
      if ($urandom_range(15, 0) == 0) bus.fu_latency_in = 9'($urandom);
      bus.flush_in = $urandom_range(24, 0) == 0;
      rst = $urandom_range(99, 0) == 0;
      tick();
    end
    rst = 1'b0;
    bus.flush_in = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
